alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, sequential successor to the 8-operation three-operand ALU.
- Takes operands a, b, c and a 3-bit opcode through a valid/ready input handshake.
- Computes the result in one cycle for logic and add ops; MUL uses an iterative shift-add multiplier over W cycles.
- Holds the registered result and flags behind a valid/ready output handshake. Sits between an operand source (sequencer/testbench driver) and a result sink.

Parameters:
- W, 4, operand width in bits (legal range 2..16).
- OUT_W, 2*W, result width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- select  input  3  opcode (see Behaviour).
- a  input  W  operand A, unsigned.
- b  input  W  operand B, unsigned.
- c  input  W  operand C, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out  output  OUT_W  result.
- out_zero  output  1  out == 0.
- out_neg  output  1  out[OUT_W-1]; meaningful for ops 1 and 2 only, forced 0 for all other ops.
- out_op  output  3  opcode that produced out.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Opcodes: operands are zero-extended to OUT_W, and all arithmetic is mod 2^OUT_W.
  - 0 ADD3: a+b+c
  - 1 ADDSUB: a+b-c
  - 2 SUB: a-b
  - 3 AND3: a&b&c
  - 4 OR3: a|b|c
  - 5 XOR3: a^b^c
  - 6 MAX3: unsigned max of a, b, c
  - 7 MUL: a*b (c ignored)
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready=out_ready.
- Accept condition: in_valid && in_ready on a rising edge.
  - Ops 0-6: result, flags and out_op are registered on that edge, and the state goes to HOLD. Latency is 1 cycle.
  - Op 7: operands are latched, the accumulator is cleared, bit counter cnt=0, and the state goes to MUL.
- MUL state:
  - Each edge: if b_shift[0] then acc += a_shift; a_shift <<= 1; b_shift >>= 1; cnt++.
  - When cnt reaches W-1 on an edge, the final accumulate is written to out and the state goes to HOLD.
  - out_valid first high W cycles after the accept edge.
- HOLD state:
  - out, out_zero, out_neg and out_op are stable while out_valid=1 && out_ready=0.
  - On out_ready=1 with no new accept: go to IDLE.
  - On out_ready=1 with a simultaneous accept: complete the output handshake and start the new op on the same edge (back-to-back). A single-cycle op stays in HOLD with the new result; MUL goes to MUL.
- in_valid while not ready: ignored; the upstream must hold its inputs.
- Changes to select/a/b/c during MUL: no effect; operands were latched at accept.
- Reset values: state=IDLE, out=0, out_zero=0, out_neg=0, out_op=0, out_valid=0, in_ready=1 from the first cycle after reset.
- Reset mid-MUL or in HOLD: the operation is discarded, with no out_valid pulse afterwards.
- Reset has priority over every handshake on the same edge.
- out_zero is computed from the final OUT_W result, including wrapped results (e.g. ADDSUB 4+4-8 gives zero=1).

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD3..OP_MUL (3'd0..3'd7);
  - state encodings ST_IDLE=2'd0, ST_MUL=2'd1, ST_HOLD=2'd2.
- Sub-module alu_mul_seq, parametrised by W:
  - iterative shift-add datapath with start, done and product ports;
  - the top FSM owns the handshake and sequencing.
- The single-cycle op mux stays in the top module as a combinational function.

Test Plan:
1. Sweep ops 0-6 with W=4, a=13, b=12, c=14, out_ready=1: outputs are 0x27, 0x0B, 0x01, 0x0C, 0x0F, 0x0F, 0x0E. out_valid is high exactly 1 cycle after each accept, and out_neg=0 throughout.
2. MUL with a=13, b=12: out=0x9C (156). out_valid rises 4 cycles after accept; in_ready=0 for those 4 cycles.
3. SUB with a=2, b=5: out=0xFD, out_neg=1, out_zero=0. Separately, ADDSUB with a=4, b=4, c=8: out=0x00, out_zero=1.
4. Backpressure: hold out_ready=0 for 5 cycles after an ADD3 result. out/out_op stay stable and in_ready=0; releasing out_ready with in_valid=1 on MUL accepts it on the same edge.
5. Reset mid-operation: assert rst 2 cycles into a MUL. The next cycle shows out_valid=0, out=0 and in_ready=1, and no stale result ever appears.
6. W=8 build: MUL with a=255, b=255 gives 0xFE01 after 8 cycles; ADD3 with 255, 255, 255 gives 0x02FD.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state encodings shared by the sequential ALU
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD3   = 3'd0;
    localparam logic [2:0] OP_ADDSUB = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_AND3   = 3'd3;
    localparam logic [2:0] OP_OR3    = 3'd4;
    localparam logic [2:0] OP_XOR3   = 3'd5;
    localparam logic [2:0] OP_MAX3   = 3'd6;
    localparam logic [2:0] OP_MUL    = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per clock over W clocks
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_product
);

    localparam int CW = $clog2(W);

    logic           r_busy;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] w_sum;

    // the final accumulate is offered on o_product in the same cycle o_done is high
    always_comb begin
        w_sum     = r_acc + (r_b[0] ? r_a : '0);
        o_product = w_sum;
        o_done    = r_busy && (r_cnt == CW'(W - 1));
    end

    // latch operands on start, then consume one multiplier bit per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= (2*W)'(i_a);
            r_b    <= i_b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc  <= w_sum;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + 1'b1;
            r_busy <= !o_done;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: three-operand ALU with valid/ready handshakes, 1-cycle ops and W-cycle MUL
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int W     = 4,
    localparam int OUT_W = 2 * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_select,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic [W-1:0]     i_c,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out,
    output logic             o_out_zero,
    output logic             o_out_neg,
    output logic [2:0]       o_out_op
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [OUT_W-1:0] r_out;
    logic             r_zero;
    logic             r_neg;
    logic [2:0]       r_op;
    logic             w_accept;
    logic             w_start;
    logic             w_mul_done;
    logic [OUT_W-1:0] w_product;
    logic [OUT_W-1:0] w_res;

    // single-cycle ops; operands zero-extended so arithmetic wraps mod 2^OUT_W
    function automatic logic [OUT_W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] c);
        logic [OUT_W-1:0] xa, xb, xc, m;
        xa = OUT_W'(a);
        xb = OUT_W'(b);
        xc = OUT_W'(c);
        m  = (xa > xb) ? xa : xb;
        m  = (xc > m) ? xc : m;
        case (op)
            OP_ADD3:   return xa + xb + xc;
            OP_ADDSUB: return xa + xb - xc;
            OP_SUB:    return xa - xb;
            OP_AND3:   return xa & xb & xc;
            OP_OR3:    return xa | xb | xc;
            OP_XOR3:   return xa ^ xb ^ xc;
            OP_MAX3:   return m;
            default:   return '0;
        endcase
    endfunction

    alu_mul_seq #(.W(W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // handshake outputs decoded from the state; HOLD passes sink readiness upstream
    always_comb begin
        o_in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_out_ready);
        o_out_valid = (r_state == ST_HOLD);
        o_out       = r_out;
        o_out_zero  = r_zero;
        o_out_neg   = r_neg;
        o_out_op    = r_op;
        w_accept    = i_in_valid && o_in_ready;
        w_start     = w_accept && (i_select == OP_MUL);
        w_res       = alu_f(i_select, i_a, i_b, i_c);
    end

    // an accept wins over draining HOLD, giving back-to-back issue
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = w_accept ? (w_start ? ST_MUL : ST_HOLD) : ST_IDLE;
            ST_HOLD: w_next = w_accept ? (w_start ? ST_MUL : ST_HOLD) : (i_out_ready ? ST_IDLE : ST_HOLD);
            ST_MUL:  w_next = w_mul_done ? ST_HOLD : ST_MUL;
            default: w_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // result register loads on a single-cycle accept or on multiplier completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_op   <= '0;
        end else if (w_accept && !w_start) begin
            r_out  <= w_res;
            r_zero <= (w_res == '0);
            r_neg  <= ((i_select == OP_ADDSUB) || (i_select == OP_SUB)) && w_res[OUT_W-1];
            r_op   <= i_select;
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_out  <= w_product;
            r_zero <= (w_product == '0);
            r_neg  <= 1'b0;
            r_op   <= OP_MUL;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at W=4 and W=8
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] out;
        logic        z;
        logic        n;
        logic [2:0]  op;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit done8 = 1'b0;

    exp_t q4[$];
    exp_t q8[$];

    logic       rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_neg;
    logic [2:0] sel, out_op;
    logic [3:0] a, b, c;
    logic [7:0] out;

    logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_neg8;
    logic [2:0]  sel8, out_op8;
    logic [7:0]  a8, b8, c8;
    logic [15:0] out8;

    alu_seq #(.W(4)) dut (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_select(sel), .i_a(a), .i_b(b), .i_c(c),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out(out),
        .o_out_zero(out_zero), .o_out_neg(out_neg), .o_out_op(out_op)
    );

    alu_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst8), .i_in_valid(in_valid8), .o_in_ready(in_ready8),
        .i_select(sel8), .i_a(a8), .i_b(b8), .i_c(c8),
        .o_out_valid(out_valid8), .i_out_ready(out_ready8), .o_out(out8),
        .o_out_zero(out_zero8), .o_out_neg(out_neg8), .o_out_op(out_op8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitors: pop an expected result on every completed output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected4: got out=%0h op=%0d with no result pending", out, out_op);
            end else chk("result4", {8'h00, out, out_zero, out_neg, out_op}, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst8 && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected8: got out=%0h op=%0d with no result pending", out8, out_op8);
            end else chk("result8", {out8, out_zero8, out_neg8, out_op8}, q8.pop_front());
        end
    end

    task automatic send4(input logic [2:0] op, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] ic, input logic [15:0] eo, input logic ez,
                         input logic en, input bit push);
        bit ok = 1'b0;
        sel = op; a = ia; b = ib; c = ic; in_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("accept4_timeout", 0, 1);
        @(posedge clk);
        if (push) q4.push_back('{eo, ez, en, op});
        #1 in_valid = 1'b0;
    endtask

    task automatic send8(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [15:0] eo);
        bit ok = 1'b0;
        sel8 = op; a8 = ia; b8 = ib; c8 = ic; in_valid8 = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready8;
        end
        if (!ok) chk("accept8_timeout", 0, 1);
        @(posedge clk);
        q8.push_back('{eo, 1'b0, 1'b0, op});
        #1 in_valid8 = 1'b0;
    endtask

    logic [7:0] sweep_exp [7] = '{8'h27, 8'h0B, 8'h01, 8'h0C, 8'h0F, 8'h0F, 8'h0E};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_flags", {out_zero, out_neg}, 0);
        chk("rst_out_op", out_op, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send4(3'(i), 4'd13, 4'd12, 4'd14, 16'(sweep_exp[i]), 1'b0, 1'b0, 1'b1);
            chk("sweep_latency", out_valid, 1);
            chk("sweep_neg", out_neg, 0);
        end
        @(posedge clk); #1;
        send4(3'd7, 4'd13, 4'd12, 4'd0, 16'h009C, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy_valid", out_valid, 0);
            chk("mul_busy_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("mul_latency", out_valid, 1);
        @(posedge clk); #1;
        send4(3'd2, 4'd2, 4'd5, 4'd0, 16'h00FD, 1'b0, 1'b1, 1'b1);
        send4(3'd1, 4'd4, 4'd4, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send4(3'd0, 4'd1, 4'd2, 4'd3, 16'h0006, 1'b0, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_out", out, 8'h06);
            chk("bp_op", out_op, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send4(3'd7, 4'd3, 4'd5, 4'd0, 16'h000F, 1'b0, 1'b0, 1'b1);
        chk("b2b_mul_started", {out_valid, in_ready}, 0);
        repeat (6) @(posedge clk);
        #1;
        send4(3'd7, 4'd7, 4'd9, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_out", out, 0);
        chk("rst_mid_ready", in_ready, 1);
        repeat (8) begin
            @(negedge clk);
            chk("rst_mid_no_stale", out_valid, 0);
        end
        for (int k = 0; k < 2000 && !done8; k++) @(posedge clk);
        chk("dut8_done", done8, 1);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1;
        sel8 = '0; a8 = '0; b8 = '0; c8 = '0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b0;
        send8(3'd7, 8'd255, 8'd255, 8'd0, 16'hFE01);
        for (int k = 0; k < 8; k++) begin
            chk("mul8_busy", out_valid8, 0);
            @(posedge clk); #1;
        end
        chk("mul8_latency", out_valid8, 1);
        send8(3'd0, 8'd255, 8'd255, 8'd255, 16'h02FD);
        repeat (3) @(posedge clk);
        done8 = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
